// File: rtl/z_mp_add_seq.sv
// z_n_csa: carry-select adder of K blocks, M bits each.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (K*M-bit operands), c_in (carry in), sum (K*M-bit result), c_out (carry out).
module z_n_csa #(
  parameter int K = 8,
  parameter int M = 4
) (
  input  logic [K*M-1:0] a,
  input  logic [K*M-1:0] b,
  input  logic           c_in,
  output logic [K*M-1:0] sum,
  output logic           c_out
);

  logic [K:0] c;

  assign c[0] = c_in;

  // Each block computes both possible results up front. The incoming carry
  // then only drives one mux per block, not a full ripple through the block.
  for (genvar j = 0; j < K; j++) begin : g_blk
    logic [M:0] s0;
    logic [M:0] s1;
    assign s0 = {1'b0, a[j*M +: M]} + {1'b0, b[j*M +: M]};
    assign s1 = s0 + {{M{1'b0}}, 1'b1};
    assign sum[j*M +: M] = c[j] ? s1[M-1:0] : s0[M-1:0];
    assign c[j+1]        = c[j] ? s1[M]     : s0[M];
  end

  assign c_out = c[K];

endmodule

// z_mp_add_seq: multi-precision adder. It adds one N-bit word per cycle,
// least-significant word first, and carries between words through carry_q.
// Latency: 1 cycle from input handshake to sum_word.
// Backpressure: a stalled output register (out_valid && !out_ready) deasserts in_ready.
// Ports: start/num_words/c_in start an operation; in_valid/in_ready/a_word/b_word
// carry the operand words; out_valid/out_ready/sum_word/out_last carry the sum words;
// c_out is the final carry; busy is high in RUN and DRAIN; done is the completion pulse.
module z_mp_add_seq #(
  parameter int N     = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a_word,
  input  logic [N-1:0]     b_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum_word,
  output logic             out_last,
  output logic             c_out,
  output logic             busy,
  output logic             done
);

  localparam int CSA_K = 8;
  localparam int CSA_M = N / CSA_K;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             carry_q,     carry_d;
  logic [N-1:0]     sum_word_q,  sum_word_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             c_out_q,     c_out_d;

  logic [N-1:0] csa_sum;
  logic         csa_cout;
  logic         in_hs;
  logic         out_hs;

  z_n_csa #(
    .K (CSA_K),
    .M (CSA_M)
  ) u_csa (
    .a     (a_word),
    .b     (b_word),
    .c_in  (carry_q),
    .sum   (csa_sum),
    .c_out (csa_cout)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    carry_d     = carry_q;
    sum_word_d  = sum_word_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    c_out_d     = c_out_q;
    in_ready    = 1'b0;
    in_hs       = 1'b0;
    out_hs      = out_valid_q && out_ready;

    case (state_q)
      S_IDLE: begin
        // A zero-length request would never produce a last word, so it is dropped.
        if (start && (num_words != '0)) begin
          remaining_d = num_words;
          carry_d     = c_in;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        // The output register can take a new word when it is empty or is
        // being drained in this same cycle.
        in_ready = !out_valid_q || out_ready;
        in_hs    = in_valid && in_ready;
        if (in_hs) begin
          sum_word_d  = csa_sum;
          carry_d     = csa_cout;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == CNT_W'(1));
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end else if (out_hs) begin
          out_valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (out_hs && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          c_out_d     = carry_q;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      carry_q     <= 1'b0;
      sum_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      c_out_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      carry_q     <= carry_d;
      sum_word_q  <= sum_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      c_out_q     <= c_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_word  = sum_word_q;
  assign out_last  = out_last_q;
  assign c_out     = c_out_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_z_mp_add_seq.sv
// Self-checking bench for z_mp_add_seq.
// Each operation's expected sum words and carry come from one wide addition.
// Ports: none.
module tb_z_mp_add_seq;

  localparam int N     = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_words = '0;
  logic             c_in = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     a_word = '0;
  logic [N-1:0]     b_word = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N-1:0]     sum_word;
  logic             out_last;
  logic             c_out;
  logic             busy;
  logic             done;

  z_mp_add_seq #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_word  (sum_word),
    .out_last  (out_last),
    .c_out     (c_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_in_ready"},  in_ready,  1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_out_last"},  out_last,  1'b0);
    chk32({tag, "_sum_word"}, sum_word,  32'h0);
    chk1({tag, "_c_out"},     c_out,     1'b0);
    chk1({tag, "_busy"},      busy,      1'b0);
    chk1({tag, "_done"},      done,      1'b0);
  endtask

  // Model state: operand words, expected outputs, captured outputs.
  logic [31:0] a_arr [16];
  logic [31:0] b_arr [16];
  logic [32:0] exp_q [$];   // {last, sum}
  logic        exp_c_q [$];
  logic [31:0] cap   [256];
  int          cap_t [256];
  int          cap_n   = 0;
  int          done_n  = 0;
  int          stall_n = 0;
  int          cyc     = 0;
  int          bp_req  = 0;
  int          bp_done = 0;
  int          stall_left = 0;

  always @(posedge clk) cyc++;

  // Sink: normally ready. On request it refuses the first sum word it sees
  // for three cycles.
  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if ((bp_req > bp_done) && out_valid) begin
      out_ready = 1'b0;
      stall_left = 2;
      bp_done++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Compare process: checks the outputs at every falling edge.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_sum   = '0;
  logic        prev_last  = 1'b0;
  bit          prev_done  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_c_q.delete();
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("stall_hold_valid", out_valid, 1'b1);
        chk32("stall_hold_sum", sum_word, prev_sum);
        chk1("stall_hold_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) begin
        chk1("stall_in_ready", in_ready, 1'b0);
        stall_n++;
      end
      if (!busy) chk1("not_busy_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        chk1("output_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk32("sum_word", sum_word, e[31:0]);
          chk1("out_last", out_last, e[32]);
        end
        cap[cap_n % 256]   = sum_word;
        cap_t[cap_n % 256] = cyc;
        cap_n++;
      end
      if (done) begin
        chk1("done_busy_low", busy, 1'b0);
        chk1("done_single_cycle", prev_done, 1'b0);
        chk1("words_all_out", exp_q.size() == 0, 1'b1);
        chk1("done_expected", exp_c_q.size() != 0, 1'b1);
        if (exp_c_q.size() != 0) chk1("c_out", c_out, exp_c_q.pop_front());
        done_n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum_word;
      prev_last  = out_last;
      prev_done  = done;
    end
  end

  // Computes the whole expected result with one wide addition, then starts the operation.
  task automatic start_op(input int n, input logic cin);
    logic [511:0] av, bv, tv;
    av = '0;
    bv = '0;
    for (int i = 0; i < n; i++) begin
      av[i*32 +: 32] = a_arr[i];
      bv[i*32 +: 32] = b_arr[i];
    end
    tv = av + bv + {511'b0, cin};
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), tv[i*32 +: 32]});
    exp_c_q.push_back(tv[n*32]);
    start     = 1'b1;
    num_words = CNT_W'(n);
    c_in      = cin;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
    chk1("in_ready_after_start", in_ready, 1'b1);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bit hs;
      int t;
      hs = 1'b0;
      t  = 0;
      a_word   = a_arr[i];
      b_word   = b_arr[i];
      in_valid = 1'b1;
      while (!hs && t < 100) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!hs) chk1("feed_timeout", hs, 1'b1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk1("done_timeout", seen, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, dn, sn;

    // Reset state
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, all ones plus carry in
    a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 32'hFFFF_FFFF;
    base = cap_n; dn = done_n;
    start_op(1, 1'b1); feed(1); wait_done();
    chk32("single_sum", cap[base], 32'hFFFF_FFFF);
    chk1("single_cout", c_out, 1'b1);
    chk_int("single_done_count", done_n - dn, 1);

    // Carry ripple across four words
    for (int i = 0; i < 4; i++) begin a_arr[i] = 32'hFFFF_FFFF; b_arr[i] = 32'h0; end
    base = cap_n; dn = done_n;
    start_op(4, 1'b1); feed(4); wait_done();
    for (int i = 0; i < 4; i++) chk32("ripple_sum", cap[base + i], 32'h0);
    chk_int("ripple_back_to_back", cap_t[base + 3] - cap_t[base], 3);
    chk1("ripple_cout", c_out, 1'b1);

    // Reset in the middle of a four-word operation
    for (int i = 0; i < 4; i++) begin a_arr[i] = 32'(i + 5); b_arr[i] = 32'h1; end
    dn = done_n;
    start_op(4, 1'b0); feed(2);
    chk1("mid_valid_before_reset", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_int("reset_no_done", done_n - dn, 0);

    // Fresh operation after reset: 5 + 7
    a_arr[0] = 32'd5; b_arr[0] = 32'd7;
    base = cap_n;
    start_op(1, 1'b0); feed(1); wait_done();
    chk32("after_reset_sum", cap[base], 32'd12);
    chk1("after_reset_cout", c_out, 1'b0);

    // Output backpressure with a carry between words
    a_arr[0] = 32'h8000_0000; b_arr[0] = 32'h8000_0000;
    a_arr[1] = 32'h1;         b_arr[1] = 32'h2;
    a_arr[2] = 32'hFFFF_FFFF; b_arr[2] = 32'h0;
    base = cap_n; sn = stall_n;
    bp_req++;
    start_op(3, 1'b0); feed(3); wait_done();
    chk_int("bp_word_count", cap_n - base, 3);
    chk32("bp_sum0", cap[base],     32'h0);
    chk32("bp_sum1", cap[base + 1], 32'h4);
    chk32("bp_sum2", cap[base + 2], 32'hFFFF_FFFF);
    chk_int("bp_stall_cycles", stall_n - sn, 3);
    chk1("bp_cout", c_out, 1'b0);

    // A start pulse during RUN must not affect the operation
    a_arr[0] = 32'h1234_5678; b_arr[0] = 32'h1111_1111;
    a_arr[1] = 32'h0;         b_arr[1] = 32'h1;
    base = cap_n; dn = done_n;
    start_op(2, 1'b0);
    fork
      feed(2);
      begin
        @(posedge clk); #1;
        start = 1'b1; num_words = CNT_W'(5);
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done();
    chk_int("ign_word_count", cap_n - base, 2);
    chk32("ign_sum0", cap[base], 32'h2345_6789);
    chk32("ign_sum1", cap[base + 1], 32'h1);
    chk_int("ign_done_count", done_n - dn, 1);

    // A start with zero words in IDLE is dropped
    base = cap_n; dn = done_n;
    start = 1'b1; num_words = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("zero_start_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk1("zero_start_busy_later", busy, 1'b0);
    chk_int("zero_start_no_output", cap_n - base, 0);
    chk_int("zero_start_no_done", done_n - dn, 0);

    // Back-to-back operations: the stale carry must not leak into the second one
    a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 32'h1;
    base = cap_n;
    start_op(1, 1'b0); feed(1); wait_done();
    chk32("b2b_first_sum", cap[base], 32'h0);
    chk1("b2b_first_cout", c_out, 1'b1);
    a_arr[0] = 32'd3; b_arr[0] = 32'd4;
    start_op(1, 1'b0); feed(1); wait_done();
    chk32("b2b_second_sum", cap[base + 1], 32'd7);
    chk1("b2b_second_cout", c_out, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/z_mp_add_seq.md
# z_mp_add_seq

Multi-precision add sequencer that drives one internal `z_n_csa` carry-select adder to add operands wider than the adder. It works one N-bit word per cycle, least-significant word first, and chains the carry between words. Operand words stream in over a valid/ready interface and sum words stream out over a second valid/ready interface. It sits between an operand source (register file or DMA) and a result sink, and is the sequential front end for the adder.

## Interface
Parameters:
- `N`, default 32: word width. Must equal the adder's `k*m` (default 8*4).
- `CNT_W`, default 4: width of the word-count field. Maximum operand length is 2^CNT_W−1 words.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a new operation. Sampled only in IDLE.
- `num_words`, in, CNT_W: number of words in the operation. Sampled with `start`.
- `c_in`, in, 1: initial carry into word 0. Sampled with `start`.
- `in_valid`, in, 1: `a_word`/`b_word` are valid.
- `in_ready`, out, 1: the sequencer accepts the word pair this cycle.
- `a_word`, in, N: operand A word.
- `b_word`, in, N: operand B word.
- `out_valid`, out, 1: `sum_word` is valid.
- `out_ready`, in, 1: the sink accepts `sum_word` this cycle.
- `sum_word`, out, N: registered sum word.
- `out_last`, out, 1: marks the final sum word of the operation.
- `c_out`, out, 1: final carry-out. Valid from `done` until the next accepted `start`.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- The adder is instantiated internally with `.a(a_word)`, `.b(b_word)`, `.c_in(carry_q)`.
- States:
  - IDLE:
    - `start`=1 and `num_words`≠0: load `remaining`←`num_words` and `carry_q`←`c_in`; go to RUN.
    - `start` with `num_words`=0 is ignored and the state stays IDLE.
  - RUN:
    - `in_ready` = `!out_valid || out_ready`.
    - On an input handshake (`in_valid && in_ready`):
      - `sum_word`←adder sum.
      - `carry_q`←adder carry-out.
      - `out_valid`←1.
      - `out_last`←(`remaining`==1).
      - `remaining`←`remaining`−1.
      - If `remaining`==1, go to DRAIN.
    - An output handshake with no input handshake in the same cycle clears `out_valid`.
  - DRAIN:
    - `in_ready`=0.
    - On the output handshake with `out_last`=1: clear `out_valid` and `out_last`, set `c_out`←`carry_q`, go to DONE.
  - DONE:
    - `done`=1 for exactly one cycle, then go to IDLE.
    - `start` is ignored in DONE.
- `start` outside IDLE is ignored and has no effect on the running operation.
- `in_ready` is 0 in IDLE, DRAIN and DONE. `in_valid` in those states is ignored.
- Arithmetic is unsigned and modulo 2^N per word. The carry propagates only through `carry_q`.
- Total result width is `num_words`·N + 1, with `c_out` as the MSB.
- `sum_word` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- `c_out` holds its value until the next operation's DONE, and is cleared by reset.

## Timing
- Reset, applied asynchronously at any time including mid-operation:
  - state←IDLE.
  - `in_ready`, `out_valid`, `out_last`, `sum_word`, `c_out`, `busy`, `done` all 0.
  - `carry_q` and `remaining` are 0.
  - The partial operation is discarded and no `done` pulse is issued.
- `start` accepted at edge t: `busy`=1 and `in_ready`=1 from cycle t+1.
- Input handshake at edge t: `out_valid`, `sum_word` and `out_last` are updated from cycle t+1. Latency is 1 cycle.
- Throughput is 1 word per cycle while `out_ready`=1. The output register passes data through, so a simultaneous output and input handshake loads the new word with no bubble.
- Last output handshake at edge t: `done`=1 and `c_out` valid in cycle t+1, with `busy`=0. IDLE from t+2, when a new `start` is accepted.
- Critical path: `carry_q`/`a_word`/`b_word` → adder → `sum_word`/`carry_q` registers, in a single cycle.

## Test plan
- Single word: `num_words`=1, `c_in`=1, a=b=32'hFFFFFFFF → `sum_word`=32'hFFFFFFFF, `out_last`=1, `c_out`=1, `done` pulses once, `busy` low in the `done` cycle.
- Carry ripple across words: `num_words`=4, `c_in`=1, every a=32'hFFFFFFFF, b=0, `out_ready`=1 → four sums of 0 on consecutive cycles, `out_last` only on the 4th, `c_out`=1.
- Backpressure: `num_words`=3, `out_ready` held 0 for 3 cycles after the first sum → `in_ready`=0 during the stall, `sum_word` stable, no words lost or duplicated. Sums are a+b with the correct carry chain (e.g. 32'h80000000+32'h80000000 → 0, with carry 1 into the next word).
- Ignored `start`: `start` pulses mid-RUN with `num_words`=5, and `start` pulses in IDLE with `num_words`=0 → the current operation completes unchanged, and no state change occurs from IDLE.
- Reset mid-operation: assert `rst_n`=0 after 2 of 4 words → all outputs are 0 immediately (asynchronously), no `done` pulse. After release, a fresh 1-word op (5+7, `c_in`=0) gives 12, `c_out`=0.
- Back-to-back operations: a second `start` in the first IDLE cycle after `done` → the second operation runs correctly. `carry_q` comes from the new `c_in`, not the stale carry.
